mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of two requester ports plus the shared single-port memory port.
// Latency: none (signal container only).
// Backpressure: requesters hold req/addr/wdata/wmask until their gnt; the memory never stalls.
//
// Ports (signals):
//   m0_*/m1_*  requester side: req, addr, wdata, wmask in; gnt, rvalid, rdata out
//   s_*        memory side: addr, wdata, wmask, rstrb out; rdata in (1 cycle after rstrb)
//   modport slave  : the arbiter's view
//   modport master : the requesters' and memory's view (testbench side)
interface mem_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wmask;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wmask;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb;
  logic [31:0] s_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_wmask,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_addr, m1_wdata, m1_wmask,
    output m1_gnt, m1_rvalid, m1_rdata,
    output s_addr, s_wdata, s_wmask, s_rstrb,
    input  s_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_wmask,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_addr, m1_wdata, m1_wmask,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  s_addr, s_wdata, s_wmask, s_rstrb,
    output s_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory (round-robin or fixed priority).
// Latency: grant is combinational; read data returns at grant+1 (memory latency only).
// Backpressure: a losing requester simply keeps req high; one transfer per cycle max.
//
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  mem_arbiter_if.slave: requester ports m0_*/m1_* and memory port s_*
module mem_arbiter #(
  parameter int RR = 1   // 1: round-robin, 0: fixed priority with M0 winning
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus
);

  // Pending-return state: RDRET means a read was granted last cycle and its
  // data is on s_rdata now.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_RDRET = 1'b1;

  logic [0:0] r_state;
  logic       r_owner;     // requester that owns the in-flight read (0 = M0)
  logic       r_last;      // most recently granted requester (0 = M0)

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_rd_gnt;
  logic       w_pending;
  logic [0:0] w_state_nxt;

  // Grant selection. Gated by rst so nothing reaches the memory during reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (RR != 0) begin
        if (bus.m0_req && bus.m1_req) begin
          // Tie: the requester not granted most recently wins.
          w_gnt0 = r_last;
          w_gnt1 = ~r_last;
        end else begin
          w_gnt0 = bus.m0_req;
          w_gnt1 = bus.m1_req;
        end
      end else begin
        w_gnt0 = bus.m0_req;
        w_gnt1 = bus.m1_req & ~bus.m0_req;
      end
    end
  end

  // A granted transfer with an all-zero mask is a read.
  assign w_rd_gnt = (w_gnt0 && (bus.m0_wmask == 4'h0)) ||
                    (w_gnt1 && (bus.m1_wmask == 4'h0));

  assign w_state_nxt = w_rd_gnt ? ST_RDRET : ST_IDLE;

  // Memory-side mux: address/data follow M1 only when M1 holds the grant.
  assign bus.s_addr  = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
  assign bus.s_wdata = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
  assign bus.s_wmask = w_gnt0 ? bus.m0_wmask :
                       w_gnt1 ? bus.m1_wmask : 4'h0;
  assign bus.s_rstrb = w_rd_gnt;

  assign bus.m0_gnt = w_gnt0;
  assign bus.m1_gnt = w_gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt0 || w_gnt1) begin
        r_last <= w_gnt1;
      end
      if (w_rd_gnt) begin
        r_owner <= w_gnt1;
      end
    end
  end

  // Return routing. Derived purely from registers, so it is glitch-free and
  // drops to 0 the instant reset clears the pending state.
  assign w_pending = (r_state == ST_RDRET);

  assign bus.m0_rvalid = w_pending & ~r_owner;
  assign bus.m1_rvalid = w_pending &  r_owner;
  assign bus.m0_rdata  = (w_pending && !r_owner) ? bus.s_rdata : 32'h0;
  assign bus.m1_rdata  = (w_pending &&  r_owner) ? bus.s_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: RR instance with a 1-cycle memory model,
// plus a fixed-priority instance for grant ordering.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  mem_arbiter_if a ();
  mem_arbiter_if b ();

  mem_arbiter #(.RR(1)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  mem_arbiter #(.RR(0)) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 64 words, byte-masked writes, read data one cycle after rstrb.
  // Preloaded while rst is high: word i = 0xA0000000 | i, word 12 = 0x11223344.
  logic [31:0] mem [0:63];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem[12]   <= 32'h1122_3344;
      a.s_rdata <= 32'h0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (a.s_wmask[k]) mem[a.s_addr[7:2]][8*k +: 8] <= a.s_wdata[8*k +: 8];
      end
      if (a.s_rstrb) a.s_rdata <= mem[a.s_addr[7:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    a.m0_req = 1'b0; a.m0_addr = 32'h0; a.m0_wdata = 32'h0; a.m0_wmask = 4'h0;
    a.m1_req = 1'b0; a.m1_addr = 32'h0; a.m1_wdata = 32'h0; a.m1_wmask = 4'h0;
    b.m0_req = 1'b0; b.m0_addr = 32'h0; b.m0_wdata = 32'h0; b.m0_wmask = 4'h0;
    b.m1_req = 1'b0; b.m1_addr = 32'h0; b.m1_wdata = 32'h0; b.m1_wmask = 4'h0;
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    b.s_rdata = 32'h0;
    rst = 1'b1;
    idle_inputs();

    // ---------------- Reset state, with requests present ----------------
    a.m0_req = 1'b1; a.m0_wmask = 4'hF;
    a.m1_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_m0_gnt",   32'(a.m0_gnt),    32'h0);
    check("rst_m1_gnt",   32'(a.m1_gnt),    32'h0);
    check("rst_s_wmask",  32'(a.s_wmask),   32'h0);
    check("rst_s_rstrb",  32'(a.s_rstrb),   32'h0);
    check("rst_m0_rvld",  32'(a.m0_rvalid), 32'h0);
    check("rst_m1_rvld",  32'(a.m1_rvalid), 32'h0);
    check("rst_m1_rdata", a.m1_rdata,       32'h0);
    do_reset();

    // ---------------- Single write then readback ----------------
    cyc();
    a.m0_req = 1'b1; a.m0_addr = 32'h10; a.m0_wdata = 32'hDEAD_BEEF; a.m0_wmask = 4'hF;
    @(negedge clk);
    check("wr_m0_gnt",  32'(a.m0_gnt),  32'h1);
    check("wr_m1_gnt",  32'(a.m1_gnt),  32'h0);
    check("wr_s_wmask", 32'(a.s_wmask), 32'hF);
    check("wr_s_addr",  a.s_addr,       32'h10);
    check("wr_s_wdata", a.s_wdata,      32'hDEAD_BEEF);
    check("wr_s_rstrb", 32'(a.s_rstrb), 32'h0);
    cyc();
    a.m0_wmask = 4'h0;
    @(negedge clk);
    check("wr_no_rvld",  32'(a.m0_rvalid), 32'h0);
    check("rd_m0_gnt",   32'(a.m0_gnt),    32'h1);
    check("rd_s_rstrb",  32'(a.s_rstrb),   32'h1);
    cyc();
    a.m0_req = 1'b0;
    @(negedge clk);
    check("rd_m0_rvld",  32'(a.m0_rvalid), 32'h1);
    check("rd_m1_rvld",  32'(a.m1_rvalid), 32'h0);
    check("rd_m0_rdata", a.m0_rdata,       32'hDEAD_BEEF);
    check("rd_m1_rdata", a.m1_rdata,       32'h0);
    check("rd_idle_gnt", 32'(a.m0_gnt),    32'h0);

    // ---------------- RR tie after reset: M0,M1,M0,M1 ----------------
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k < 4) begin
        a.m0_req = 1'b1; a.m0_addr = 32'h40; a.m0_wmask = 4'h0;
        a.m1_req = 1'b1; a.m1_addr = 32'h80; a.m1_wmask = 4'h0;
      end else begin
        a.m0_req = 1'b0;
        a.m1_req = 1'b0;
      end
      @(negedge clk);
      if (k < 4) begin
        check($sformatf("rr_m0_gnt%0d", k), 32'(a.m0_gnt), (k % 2 == 0) ? 32'h1 : 32'h0);
        check($sformatf("rr_m1_gnt%0d", k), 32'(a.m1_gnt), (k % 2 == 1) ? 32'h1 : 32'h0);
        check($sformatf("rr_s_addr%0d", k), a.s_addr, (k % 2 == 0) ? 32'h40 : 32'h80);
      end
      if (k == 0) begin
        check("rr_m0_rvld0", 32'(a.m0_rvalid), 32'h0);
        check("rr_m1_rvld0", 32'(a.m1_rvalid), 32'h0);
      end else if (k % 2 == 1) begin
        check($sformatf("rr_m0_rvld%0d", k), 32'(a.m0_rvalid), 32'h1);
        check($sformatf("rr_m1_rvld%0d", k), 32'(a.m1_rvalid), 32'h0);
        check($sformatf("rr_m0_rdata%0d", k), a.m0_rdata, 32'hA000_0010);
      end else begin
        check($sformatf("rr_m0_rvld%0d", k), 32'(a.m0_rvalid), 32'h0);
        check($sformatf("rr_m1_rvld%0d", k), 32'(a.m1_rvalid), 32'h1);
        check($sformatf("rr_m1_rdata%0d", k), a.m1_rdata, 32'hA000_0020);
      end
    end

    // ---------------- Fixed priority instance ----------------
    for (int k = 0; k < 4; k++) begin
      cyc();
      b.m0_req = (k < 3);
      b.m1_req = 1'b1;
      @(negedge clk);
      check($sformatf("fp_m0_gnt%0d", k), 32'(b.m0_gnt), (k < 3) ? 32'h1 : 32'h0);
      check($sformatf("fp_m1_gnt%0d", k), 32'(b.m1_gnt), (k < 3) ? 32'h0 : 32'h1);
    end
    b.m1_req = 1'b0;

    // ---------------- Mixed: M0 write and M1 read of the same word ----------------
    do_reset();
    cyc();
    a.m0_req = 1'b1; a.m0_addr = 32'h20; a.m0_wdata = 32'h1234_5678; a.m0_wmask = 4'hF;
    a.m1_req = 1'b1; a.m1_addr = 32'h20; a.m1_wmask = 4'h0;
    @(negedge clk);
    check("mx_m0_gnt", 32'(a.m0_gnt), 32'h1);
    check("mx_m1_gnt", 32'(a.m1_gnt), 32'h0);
    cyc();
    a.m0_req = 1'b0;
    @(negedge clk);
    check("mx_m1_gnt2",  32'(a.m1_gnt),  32'h1);
    check("mx_s_rstrb",  32'(a.s_rstrb), 32'h1);
    check("mx_s_wmask",  32'(a.s_wmask), 32'h0);
    cyc();
    a.m1_req = 1'b0;
    @(negedge clk);
    check("mx_m1_rvld",  32'(a.m1_rvalid), 32'h1);
    check("mx_m0_rvld",  32'(a.m0_rvalid), 32'h0);
    check("mx_m1_rdata", a.m1_rdata,       32'h1234_5678);
    check("mx_idle_rstrb", 32'(a.s_rstrb), 32'h0);

    // ---------------- Partial write over 0x11223344 ----------------
    cyc();
    a.m0_req = 1'b1; a.m0_addr = 32'h30; a.m0_wdata = 32'hAAAA_5555; a.m0_wmask = 4'h3;
    @(negedge clk);
    check("pw_s_wmask", 32'(a.s_wmask), 32'h3);
    cyc();
    a.m0_wmask = 4'h0;
    @(negedge clk);
    check("pw_rd_gnt", 32'(a.m0_gnt), 32'h1);
    cyc();
    a.m0_req = 1'b0;
    @(negedge clk);
    check("pw_m0_rvld",  32'(a.m0_rvalid), 32'h1);
    check("pw_m0_rdata", a.m0_rdata,       32'h1122_5555);

    // ---------------- Reset while an M1 read is in flight ----------------
    cyc();
    a.m1_req = 1'b1; a.m1_addr = 32'h40; a.m1_wmask = 4'h0;
    @(negedge clk);
    check("rm_m1_gnt", 32'(a.m1_gnt), 32'h1);
    rst = 1'b1;
    a.m1_req = 1'b0;
    @(negedge clk);
    check("rm_rst_m1_rvld", 32'(a.m1_rvalid), 32'h0);
    check("rm_rst_m1_rdata", a.m1_rdata,      32'h0);
    rst = 1'b0;
    cyc();
    a.m0_req = 1'b1; a.m0_addr = 32'h40; a.m0_wmask = 4'h0;
    a.m1_req = 1'b1; a.m1_addr = 32'h80; a.m1_wmask = 4'h0;
    @(negedge clk);
    check("rm_post_m1_rvld", 32'(a.m1_rvalid), 32'h0);
    check("rm_tie_m0_gnt",   32'(a.m0_gnt),    32'h1);
    check("rm_tie_m1_gnt",   32'(a.m1_gnt),    32'h0);
    cyc();
    a.m0_req = 1'b0;
    a.m1_req = 1'b0;
    @(negedge clk);
    check("rm_m0_rvld",  32'(a.m0_rvalid), 32'h1);
    check("rm_m1_rvld",  32'(a.m1_rvalid), 32'h0);
    check("rm_m0_rdata", a.m0_rdata,       32'hA000_0010);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
